lzss_encoder: RTL and testbench
===============================

// Module: lzss_encoder
// PURPOSE
// Streaming LZSS compressor: accepts one WORD_SIZE byte per enabled cycle, emits literal/reference tokens.
// Sits after the zig-zag/entropy front end; feeds the token packer.
// Keeps a sliding history window and a look-ahead buffer; one encode decision per accepted byte.
// Throughput: 1 input/cycle, no backpressure.
// PARAMETERS
// WORD_SIZE        8   input symbol width; token payload width
// WINDOW_SIZE      32  history depth (max match distance); power of 2
// LOOK_AHEAD_SIZE  4   look-ahead depth (max match length)
// PORTS
// clk      in   1            rising-edge clock
// rst      in   1            synchronous reset, active-high
// w_en     in   1            data_i valid; each high cycle accepts one byte
// data_i   in   WORD_SIZE    input byte
// data_o   out  WORD_SIZE+1  token: [WORD_SIZE]=1 reference, 0 literal
// o_ready  out  1            data_o holds a new token this cycle (1-cycle strobe)
// BEHAVIOUR
// - Token format:
//   - Literal: {1'b0, byte}.
//   - Reference: {1'b1, 0-pad, off[OW-1:0], len[LW-1:0]}, OW=$clog2(WINDOW_SIZE), LW=$clog2(LOOK_AHEAD_SIZE+1).
//   - off = distance-1; len = match length. Defaults: off in [7:3], len in [2:0].
//   - Elaboration error if OW+LW > WORD_SIZE.
// - Reset (rst high at edge): data_o=0, o_ready=0, window and look-ahead valid counts=0, skip=0.
//   - Reset wins over w_en. Reset mid-stream discards all history.
// - Storage: LA[0..LOOK_AHEAD_SIZE-1], LA[0]=head. Window W[1..WINDOW_SIZE], W[d]=byte d positions before the head.
// - Accept edge (w_en=1, rst=0):
//   - LA shifts toward head; data_i enters the tail.
//   - Old head enters W[1]; the oldest window byte drops.
// - w_en=0: full stall. No state change, o_ready=0, data_o holds its value.
// - Encode happens on an accept edge only when the look-ahead is full. It acts on the current (pre-shift) head:
//   - skip>0: skip<=skip-1, o_ready<=0 (head byte is covered by an earlier reference).
//   - skip==0, search:
//     - For each distance d=1..WINDOW_SIZE with d <= window valid count, compute len(d).
//     - len(d) = count of leading k where LA[k] == stream byte at (head+k-d). That byte may lie in LA (overlap allowed).
//     - len(d) is capped at LOOK_AHEAD_SIZE.
//     - Best = longest; tie -> smallest d.
//     - If best >= 2: emit reference, skip <= best-1. Else emit literal of LA[0].
//     - o_ready<=1 and data_o registered on that edge.
// - Latency: byte accepted at edge N is encoded at edge N+LOOK_AHEAD_SIZE, provided w_en stays high.
//   - First o_ready follows the (LOOK_AHEAD_SIZE+1)th accepted byte.
// - No flush: the last LOOK_AHEAD_SIZE bytes are encoded only as further bytes are pushed.
// - Window not yet full: distances beyond the valid count are never matched.
// - Search is combinational, registered output; a single-cycle decision is required.
// TESTING
// 1. Hold rst=1 with w_en=1 for 3 cycles -> o_ready=0, data_o=0x000 throughout.
// 2. Push 3A,35,DC,FE,FC,F1 -> literals 0x03A,0x035 on the 5th and 6th accepts. No o_ready before the 5th accept.
// 3. From reset push 07, then 00 x9, then FF x4 -> tokens in order:
//    - 0x007, 0x000 (literal)
//    - 0x104 (d=1, len 4), 0x104 (d=1, len 4)
//    - Gaps of 3 cycles with o_ready=0 follow each reference.
// 4. From reset push 01,02,01,02,01,02,AA x4 -> 0x001, 0x002, 0x10C (d=2, len 4).
// 5. Drop w_en for 5 cycles mid-stream -> o_ready=0 and outputs frozen; token sequence after resume identical to the uninterrupted run.
// 6. Push byte X, then 32 distinct bytes, then X, then 4 more bytes -> X re-emitted as a literal (distance 33 out of range).
//    Repeat with distance 32 -> match with off field = 31.

Source files
------------

// File: rtl/lzss_if.sv
// Byte-in / token-out handshake between the LZSS encoder and its neighbours.
interface lzss_if #(parameter int WORD_SIZE = 8) ();
  logic                 w_en;
  logic [WORD_SIZE-1:0] data_i;
  logic [WORD_SIZE:0]   data_o;
  logic                 o_ready;

  modport master (output w_en, data_i, input  data_o, o_ready);
  modport slave  (input  w_en, data_i, output data_o, o_ready);
endinterface

// File: rtl/lzss_encoder.sv
// Streaming LZSS encoder: sliding window + look-ahead, one combinational
// longest-match search per accepted byte, registered literal/reference token.
module lzss_match_len #(
  parameter int WORD_SIZE       = 8,
  parameter int LOOK_AHEAD_SIZE = 4,
  parameter int LW              = 3
) (
  input  logic                                       en,
  input  logic [LOOK_AHEAD_SIZE-1:0][WORD_SIZE-1:0]  la,
  input  logic [LOOK_AHEAD_SIZE-1:0][WORD_SIZE-1:0]  cand,
  output logic [LW-1:0]                              len
);
  logic run;

  always_comb begin
    len = '0;
    run = en;
    for (int k = 0; k < LOOK_AHEAD_SIZE; k++) begin
      if (run && la[k] == cand[k]) len = len + LW'(1);
      else                         run = 1'b0;
    end
  end
endmodule

module lzss_encoder #(
  parameter int WORD_SIZE       = 8,
  parameter int WINDOW_SIZE     = 32,
  parameter int LOOK_AHEAD_SIZE = 4
) (
  input  logic   clk,
  input  logic   rst,
  lzss_if.slave  bus
);
  localparam int OW = $clog2(WINDOW_SIZE);
  localparam int LW = $clog2(LOOK_AHEAD_SIZE + 1);
  localparam int CW = $clog2(WINDOW_SIZE + 1);
  localparam int HN = WINDOW_SIZE + LOOK_AHEAD_SIZE;

  if (OW + LW > WORD_SIZE) begin : g_bad_cfg
    $error("lzss_encoder: offset+length fields do not fit in WORD_SIZE");
  end

  logic [LOOK_AHEAD_SIZE-1:0][WORD_SIZE-1:0] la;
  logic [LOOK_AHEAD_SIZE-1:0]                la_vld;
  logic [WINDOW_SIZE-1:0][WORD_SIZE-1:0]     win;   // win[i] is the byte i+1 before the head
  logic [CW-1:0]                             win_cnt;
  logic [LW-1:0]                             skip;
  logic [WORD_SIZE:0]                        data_q;
  logic                                      rdy_q;

  // Oldest window byte first, head at index WINDOW_SIZE; lets overlapping
  // matches read straight into the look-ahead.
  logic [HN-1:0][WORD_SIZE-1:0]              hist;
  logic [WINDOW_SIZE-1:0][LW-1:0]            lens;

  for (genvar i = 0; i < HN; i++) begin : g_hist
    if (i < WINDOW_SIZE) begin : g_w
      assign hist[i] = win[WINDOW_SIZE-1-i];
    end else begin : g_l
      assign hist[i] = la[i-WINDOW_SIZE];
    end
  end

  for (genvar d = 1; d <= WINDOW_SIZE; d++) begin : g_dist
    logic [LOOK_AHEAD_SIZE-1:0][WORD_SIZE-1:0] cand;
    for (genvar k = 0; k < LOOK_AHEAD_SIZE; k++) begin : g_c
      assign cand[k] = hist[WINDOW_SIZE+k-d];
    end
    lzss_match_len #(
      .WORD_SIZE(WORD_SIZE), .LOOK_AHEAD_SIZE(LOOK_AHEAD_SIZE), .LW(LW)
    ) u_ml (
      .en   (win_cnt >= CW'(d)),
      .la   (la),
      .cand (cand),
      .len  (lens[d-1])
    );
  end

  logic [LW-1:0]      best_len;
  logic [OW-1:0]      best_off;
  logic               use_ref;
  logic [WORD_SIZE:0] tok;

  // Strict '>' on an ascending scan keeps the smallest distance on ties.
  always_comb begin
    best_len = '0;
    best_off = '0;
    for (int i = 0; i < WINDOW_SIZE; i++) begin
      if (lens[i] > best_len) begin
        best_len = lens[i];
        best_off = OW'(i);
      end
    end
    use_ref = {1'b0, best_len} >= (LW+1)'(2);
    tok     = {1'b0, la[0]};
    if (use_ref) begin
      tok               = '0;
      tok[WORD_SIZE]    = 1'b1;
      tok[LW-1:0]       = best_len;
      tok[OW+LW-1:LW]   = best_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      la      <= '0;
      la_vld  <= '0;
      win     <= '0;
      win_cnt <= '0;
      skip    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.w_en) begin
        la     <= {bus.data_i, la[LOOK_AHEAD_SIZE-1:1]};
        la_vld <= {1'b1, la_vld[LOOK_AHEAD_SIZE-1:1]};
        win    <= {win[WINDOW_SIZE-2:0], la[0]};
        if (la_vld[0] && win_cnt != CW'(WINDOW_SIZE)) win_cnt <= win_cnt + CW'(1);
        if (la_vld[0]) begin
          if (skip != '0) begin
            skip <= skip - LW'(1);
          end else begin
            rdy_q  <= 1'b1;
            data_q <= tok;
            if (use_ref) skip <= best_len - LW'(1);
          end
        end
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.o_ready = rdy_q;
endmodule

// File: tb/tb_lzss_encoder.sv
// Directed-vector bench for lzss_encoder with hand-computed token streams.
module tb_lzss_encoder;
  logic clk = 1'b0;
  logic rst;

  lzss_if #(.WORD_SIZE(8)) bus ();

  lzss_encoder #(.WORD_SIZE(8), .WINDOW_SIZE(32), .LOOK_AHEAD_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc;
  logic [63:0] rdy_vec;
  logic [8:0]  got[$];
  logic [7:0]  stim[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tok(input string tag, input int idx, input logic [8:0] exp);
    if (idx < got.size()) chk(tag, {23'd0, got[idx]}, {23'd0, exp});
    else                  chk(tag, 32'hFFFF_FFFF, {23'd0, exp});
  endtask

  task automatic push(input logic [7:0] b);
    bus.w_en   = 1'b1;
    bus.data_i = b;
    @(posedge clk); #1;
    n_acc++;
    if (bus.o_ready) begin
      got.push_back(bus.data_o);
      rdy_vec[n_acc-1] = 1'b1;
    end
    bus.w_en = 1'b0;
  endtask

  task automatic push_stim();
    foreach (stim[i]) push(stim[i]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_i = 8'($urandom);
      @(posedge clk); #1;
      chk("rst_rdy", {31'd0, bus.o_ready}, 32'd0);
      chk("rst_dat", {23'd0, bus.data_o}, 32'd0);
    end
    rst      = 1'b0;
    bus.w_en = 1'b0;
    n_acc    = 0;
    rdy_vec  = '0;
    got.delete();
    stim.delete();
  endtask

  initial begin
    rst        = 1'b1;
    bus.w_en   = 1'b0;
    bus.data_i = '0;
    do_reset();

    // Literals only; first token after the 5th accept
    stim = '{8'h3A, 8'h35, 8'hDC, 8'hFE, 8'hFC, 8'hF1};
    push_stim();
    chk("t2_rdy", {26'd0, rdy_vec[5:0]}, 32'h30);
    chk("t2_n", got.size(), 2);
    chk_tok("t2_tok0", 0, 9'h03A);
    chk_tok("t2_tok1", 1, 9'h035);

    // Reset while data_o is non-zero must clear it and drop history
    do_reset();

    stim.push_back(8'h07);
    for (int i = 0; i < 9; i++) stim.push_back(8'h00);
    for (int i = 0; i < 4; i++) stim.push_back(8'hFF);
    push_stim();
    chk("t3_rdy", {18'd0, rdy_vec[13:0]}, 32'h0470);
    chk("t3_n", got.size(), 4);
    chk_tok("t3_tok0", 0, 9'h007);
    chk_tok("t3_tok1", 1, 9'h000);
    chk_tok("t3_tok2", 2, 9'h104);
    chk_tok("t3_tok3", 3, 9'h104);

    do_reset();
    stim = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    push_stim();
    chk("t4_n", got.size(), 3);
    chk_tok("t4_tok0", 0, 9'h001);
    chk_tok("t4_tok1", 1, 9'h002);
    chk_tok("t4_tok2", 2, 9'h10C);

    // Same stream with a 5-cycle stall right after the second literal
    do_reset();
    stim = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    for (int i = 0; i < 6; i++) push(stim[i]);
    chk("t5_pre", {23'd0, bus.data_o}, 32'h002);
    bus.w_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.data_i = 8'($urandom);
      @(posedge clk); #1;
      chk("t5_stall_rdy", {31'd0, bus.o_ready}, 32'd0);
      chk("t5_stall_dat", {23'd0, bus.data_o}, 32'h002);
    end
    for (int i = 6; i < 10; i++) push(stim[i]);
    chk("t5_n", got.size(), 3);
    chk_tok("t5_tok0", 0, 9'h001);
    chk_tok("t5_tok1", 1, 9'h002);
    chk_tok("t5_tok2", 2, 9'h10C);

    // X repeats at distance 33: out of window, literal again
    do_reset();
    stim.push_back(8'hAA);
    for (int i = 0; i < 32; i++) stim.push_back(8'(i));
    stim.push_back(8'hAA);
    for (int i = 0; i < 4; i++) stim.push_back(8'hB0 + 8'(i));
    push_stim();
    chk("t6a_n", got.size(), 34);
    chk_tok("t6a_tok0", 0, 9'h0AA);
    chk_tok("t6a_tok33", 33, 9'h0AA);

    // X repeats at distance 32 followed by the same bytes: reference, off=31
    do_reset();
    stim.push_back(8'hAA);
    for (int i = 0; i < 31; i++) stim.push_back(8'(i));
    stim.push_back(8'hAA);
    for (int i = 0; i < 4; i++) stim.push_back(8'(i));
    push_stim();
    chk("t6b_n", got.size(), 33);
    chk_tok("t6b_tok31", 31, 9'h01E);
    chk_tok("t6b_tok32", 32, 9'h1FC);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
